// File: rtl/button_if.sv
// Button channel bundle: raw inputs in, conditioned level and event pulses out.
interface button_if #(
  parameter int N_BTN = 2
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_db;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic [N_BTN-1:0] btn_hold;

  modport master (
    output btn_in,
    input  btn_db,
    input  btn_rise,
    input  btn_fall,
    input  btn_hold
  );

  modport slave (
    input  btn_in,
    output btn_db,
    output btn_rise,
    output btn_fall,
    output btn_hold
  );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: per channel a 2-FF synchroniser followed by a
// counter-based debounce FSM producing a clean level, press/release pulses
// and a one-shot long-press pulse.
//
// state | meaning
// ------+---------------------------------------------------------------
// UP    | released and stable, waiting for the synchronised input to go high
// PCHK  | input high, counting consecutive high cycles before accepting a press
// DOWN  | pressed and stable, hold timer running (saturating)
// RCHK  | input low, counting consecutive low cycles before accepting a release
module button_debouncer #(
  parameter int N_BTN       = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 100000000
) (
  input logic    clk,
  input logic    rst_n,
  button_if.slave bus
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

  typedef enum logic [1:0] {UP, PCHK, DOWN, RCHK} state_t;

  state_t [N_BTN-1:0]          state;
  logic   [N_BTN-1:0][CW-1:0]  cnt;
  logic   [N_BTN-1:0][HW-1:0]  hold_cnt;
  logic   [N_BTN-1:0]          s1, s2;
  logic   [N_BTN-1:0]          db_q, rise_q, fall_q, hold_q;

  // Bring the asynchronous button inputs into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_in;
      s2 <= s1;
    end
  end

  // Debounce FSM per channel; all outputs are registered, pulses default low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= UP;
      end
      cnt      <= '0;
      hold_cnt <= '0;
      db_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      hold_q   <= '0;
    end else begin
      rise_q <= '0;
      fall_q <= '0;
      hold_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          UP: begin
            if (s2[i]) begin
              state[i] <= PCHK;
              cnt[i]   <= CNT_ONE;
            end
          end
          PCHK: begin
            if (!s2[i]) begin
              state[i] <= UP;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i]    <= DOWN;
              cnt[i]      <= '0;
              hold_cnt[i] <= '0;
              db_q[i]     <= 1'b1;
              rise_q[i]   <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          DOWN: begin
            if (!s2[i]) begin
              state[i] <= RCHK;
              cnt[i]   <= CNT_ONE;
            end else begin
              // Saturation keeps the long-press pulse to one per press.
              if (hold_cnt[i] != HOLD_MAX) begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
              if (hold_cnt[i] == HOLD_LAST) begin
                hold_q[i] <= 1'b1;
              end
            end
          end
          RCHK: begin
            if (s2[i]) begin
              state[i] <= DOWN;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= UP;
              cnt[i]   <= '0;
              db_q[i]  <= 1'b0;
              fall_q[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= UP;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_db   = db_q;
  assign bus.btn_rise = rise_q;
  assign bus.btn_fall = fall_q;
  assign bus.btn_hold = hold_q;
endmodule
